// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - shared FSM states, opcodes and mem_state encodings for the LC-3 fetch controller
// Contents:
//   state_t       controller FSM states
//   OP_*          LC-3 opcodes (IR[15:12]) the controller distinguishes
//   MS_*          mem_state encodings presented to the memory stage
//   exec_next     successor of EXECUTE for a given opcode
//   mem_state_of  mem_state value shown while in a given state
//   is_wait_state states whose dwell time is bounded by the timeout counter
package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM_IND,
        ST_MEM_READ,
        ST_MEM_WRITE,
        ST_WRITEBACK,
        ST_UPDATE_PC
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    // Unlisted opcodes are retired as NOPs straight through UPDATE_PC.
    function automatic state_t exec_next(input logic [3:0] op);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: exec_next = ST_WRITEBACK;
            OP_LD, OP_LDR:                  exec_next = ST_MEM_READ;
            OP_LDI, OP_STI:                 exec_next = ST_MEM_IND;
            OP_ST, OP_STR:                  exec_next = ST_MEM_WRITE;
            default:                        exec_next = ST_UPDATE_PC;
        endcase
    endfunction

    function automatic logic [1:0] mem_state_of(input state_t s);
        case (s)
            ST_MEM_IND:   mem_state_of = MS_IND;
            ST_MEM_READ:  mem_state_of = MS_READ;
            ST_MEM_WRITE: mem_state_of = MS_WRITE;
            default:      mem_state_of = MS_IDLE;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        is_wait_state = (s == ST_FETCH) || (s == ST_MEM_IND) ||
                        (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/lc3_fetch_ctrl_if.sv
// rtl/lc3_fetch_ctrl_if.sv - handshake/control bundle between the fetch controller and the datapath
// Signals:
//   complete_instr, complete_data  memory completion strobes (datapath -> controller)
//   IR, NZP, psr                   decoded instruction, branch field, condition codes
//   enable_*                       one-hot stage enables (controller -> datapath)
//   br_taken, mem_state, mem_err   PC redirect, memory access kind, timeout pulse
// Modports: master = controller side, slave = datapath side.
interface lc3_fetch_ctrl_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        mem_err;

    modport master (
        input  complete_instr, complete_data, IR, NZP, psr,
        output enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, mem_err
    );

    modport slave (
        output complete_instr, complete_data, IR, NZP, psr,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, mem_err
    );
endinterface

// File: rtl/lc3_br_eval.sv
// rtl/lc3_br_eval.sv - branch/jump redirect decision
// Ports:
//   opcode  in  IR[15:12]
//   nzp     in  branch condition field
//   psr     in  current condition codes (n,z,p)
//   taken   out 1 for JMP, or for BR whose condition matches psr
module lc3_br_eval
    import lc3_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] nzp,
    input  logic [2:0] psr,
    output logic       taken
);
    assign taken = (opcode == OP_JMP) ||
                   ((opcode == OP_BR) && ((nzp & psr) != 3'b000));
endmodule

// File: rtl/lc3_fetch_ctrl.sv
// rtl/lc3_fetch_ctrl.sv - LC-3 multi-cycle fetch/decode/execute/memory/writeback sequencer
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   bus          lc3_fetch_ctrl_if.master (completions, IR/NZP/psr in; enables, br_taken, mem_state, mem_err out)
//   retired_cnt  16-bit UPDATE_PC counter, present only with FETCH_CTRL_PERF_EN defined
// Parameter TIMEOUT_CYCLES bounds the dwell in FETCH and the memory states.
module lc3_fetch_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    lc3_fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] retired_cnt
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          en_fetch_q, en_fetch_d;
    logic          en_decode_q, en_decode_d;
    logic          en_execute_q, en_execute_d;
    logic          en_writeback_q, en_writeback_d;
    logic          en_update_pc_q, en_update_pc_d;
    logic          br_taken_q, br_taken_d;
    logic [1:0]    mem_state_q, mem_state_d;
    logic          mem_err_q, mem_err_d;
    logic          timed_out;
    logic          wait_expired;
    logic          br_hit;
    logic [3:0]    opcode;
    logic          unused_ir;

    assign opcode    = bus.IR[15:12];
    assign unused_ir = ^bus.IR[11:0];

    lc3_br_eval u_br_eval (
        .opcode (opcode),
        .nzp    (bus.NZP),
        .psr    (bus.psr),
        .taken  (br_hit)
    );

    // Last permitted waiting cycle: a completion here still wins over the timeout.
    assign wait_expired = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        timed_out = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.complete_instr) state_d = ST_DECODE;
                else if (wait_expired)  timed_out = 1'b1;
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = exec_next(opcode);
            ST_MEM_IND: begin
                if (bus.complete_data)
                    state_d = (opcode == OP_LDI) ? ST_MEM_READ : ST_MEM_WRITE;
                else if (wait_expired)
                    timed_out = 1'b1;
            end
            ST_MEM_READ: begin
                if (bus.complete_data) state_d = ST_WRITEBACK;
                else if (wait_expired) timed_out = 1'b1;
            end
            ST_MEM_WRITE: begin
                if (bus.complete_data) state_d = ST_UPDATE_PC;
                else if (wait_expired) timed_out = 1'b1;
            end
            ST_WRITEBACK: state_d = ST_UPDATE_PC;
            ST_UPDATE_PC: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
        if (timed_out) state_d = ST_UPDATE_PC;

        wait_cnt_d = ((state_d == state_q) && is_wait_state(state_q)) ? wait_cnt_q + 1'b1 : '0;

        // Outputs are decoded from the next state so they line up with state_q.
        en_fetch_d     = (state_d == ST_FETCH);
        en_decode_d    = (state_d == ST_DECODE);
        en_execute_d   = (state_d == ST_EXECUTE);
        en_writeback_d = (state_d == ST_WRITEBACK);
        en_update_pc_d = (state_d == ST_UPDATE_PC);
        // Only the EXECUTE->UPDATE_PC path carries BR/JMP; timeouts never redirect.
        br_taken_d     = (state_q == ST_EXECUTE) && (state_d == ST_UPDATE_PC) && br_hit;
        mem_state_d    = mem_state_of(state_d);
        mem_err_d      = timed_out;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            wait_cnt_q     <= '0;
            // FETCH's own decode, so the first cycle after reset already fetches;
            // the output gating below holds everything low while reset is high.
            en_fetch_q     <= 1'b1;
            en_decode_q    <= 1'b0;
            en_execute_q   <= 1'b0;
            en_writeback_q <= 1'b0;
            en_update_pc_q <= 1'b0;
            br_taken_q     <= 1'b0;
            mem_state_q    <= MS_IDLE;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            en_fetch_q     <= en_fetch_d;
            en_decode_q    <= en_decode_d;
            en_execute_q   <= en_execute_d;
            en_writeback_q <= en_writeback_d;
            en_update_pc_q <= en_update_pc_d;
            br_taken_q     <= br_taken_d;
            mem_state_q    <= mem_state_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign bus.enable_fetch     = en_fetch_q     & ~reset;
    assign bus.enable_decode    = en_decode_q    & ~reset;
    assign bus.enable_execute   = en_execute_q   & ~reset;
    assign bus.enable_writeback = en_writeback_q & ~reset;
    assign bus.enable_updatePC  = en_update_pc_q & ~reset;
    assign bus.br_taken         = br_taken_q     & ~reset;
    assign bus.mem_err          = mem_err_q      & ~reset;
    assign bus.mem_state        = reset ? MS_IDLE : mem_state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (state_q == ST_UPDATE_PC) retired_cnt_d = retired_cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) retired_cnt_q <= 16'd0;
        else       retired_cnt_q <= retired_cnt_d;
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// tb/tb_lc3_fetch_ctrl.sv - randomized self-checking bench for lc3_fetch_ctrl
module tb_lc3_fetch_ctrl;
    import lc3_ctrl_pkg::*;

    localparam int TO = 64;
    localparam logic [4:0] EN_F = 5'b10000;
    localparam logic [4:0] EN_D = 5'b01000;
    localparam logic [4:0] EN_E = 5'b00100;
    localparam logic [4:0] EN_W = 5'b00010;
    localparam logic [4:0] EN_U = 5'b00001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    lc3_fetch_ctrl_if bus();
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] retired_cnt;
`endif

    lc3_fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clock = ~clock;

    // One entry per clock: inputs to drive and the observation expected in that cycle.
    typedef struct {
        logic [9:0]  exp;    // {F,D,E,W,U enables, br_taken, mem_state, mem_err}
        logic        ci;
        logic        cd;
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic [2:0]  psr;
    } cyc_t;

    cyc_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cur_ir;
    logic [2:0]  cur_nzp, cur_psr;

    function automatic void push(logic [4:0] en, logic br, logic [1:0] ms, logic err,
                                 logic ci, logic cd);
        cyc_t c;
        c.exp = {en, br, ms, err};
        c.ci  = ci;
        c.cd  = cd;
        c.ir  = cur_ir;
        c.nzp = cur_nzp;
        c.psr = cur_psr;
        q.push_back(c);
    endfunction

    // A wait lasts until completion after d idle cycles, or at most TO cycles;
    // exhausting it costs one UPDATE_PC cycle with mem_err. Returns 1 on timeout.
    function automatic bit wait_phase(logic [4:0] en, logic [1:0] ms, int d, bit instr);
        int n = (d < TO) ? d + 1 : TO;
        for (int k = 0; k < n; k++)
            push(en, 1'b0, ms, 1'b0, instr && (k == d), !instr && (k == d));
        if (d >= TO) push(EN_U, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        return d >= TO;
    endfunction

    function automatic void add_instr(logic [15:0] ir, logic [2:0] nzp, logic [2:0] psr,
                                      int df, int d1, int d2);
        logic [3:0] op = ir[15:12];
        cur_ir  = ir;
        cur_nzp = nzp;
        cur_psr = psr;
        if (wait_phase(EN_F, 2'd3, df, 1'b1)) return;
        push(EN_D, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        push(EN_E, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
                push(EN_W, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
                push(EN_U, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
            end
            OP_LD, OP_LDR: begin
                if (wait_phase(5'b0, 2'd0, d1, 1'b0)) return;
                push(EN_W, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
                push(EN_U, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
            end
            OP_LDI: begin
                if (wait_phase(5'b0, 2'd1, d1, 1'b0)) return;
                if (wait_phase(5'b0, 2'd0, d2, 1'b0)) return;
                push(EN_W, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
                push(EN_U, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
            end
            OP_STI: begin
                if (wait_phase(5'b0, 2'd1, d1, 1'b0)) return;
                if (wait_phase(5'b0, 2'd2, d2, 1'b0)) return;
                push(EN_U, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
            end
            OP_ST, OP_STR: begin
                if (wait_phase(5'b0, 2'd2, d1, 1'b0)) return;
                push(EN_U, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
            end
            default:
                push(EN_U, (op == OP_JMP) || (op == OP_BR && (nzp & psr) != 3'b000),
                     2'd3, 1'b0, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic logic [9:0] observe();
        return {bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                bus.enable_writeback, bus.enable_updatePC, bus.br_taken,
                bus.mem_state, bus.mem_err};
    endfunction

    // Entered just after a rising edge; leaves just after the edge that ends the last entry.
    task automatic run_queue(input string name, input int max_cycles);
        logic [9:0] act;
        int n = (max_cycles < q.size()) ? max_cycles : q.size();
        for (int i = 0; i < n; i++) begin
            bus.complete_instr = q[i].ci;
            bus.complete_data  = q[i].cd;
            bus.IR             = q[i].ir;
            bus.NZP            = q[i].nzp;
            bus.psr            = q[i].psr;
            @(negedge clock);
            act = observe();
            checks++;
            @(posedge clock);
            #1;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, act, q[i].exp);
                break;
            end
        end
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] act;
        reset              = 1'b1;
        bus.complete_instr = 1'b1;
        bus.complete_data  = 1'b1;
        bus.IR             = 16'h1261;
        bus.NZP            = 3'b111;
        bus.psr            = 3'b111;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            act = observe();
            checks++;
            if (act !== 10'b00000_0_11_0) begin
                errors++;
                $display("FAIL reset_hold %0d: got %b expected %b", i, act, 10'b00000_0_11_0);
            end
        end
        @(posedge clock);
        #1;
        reset              = 1'b0;
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        @(negedge clock);
        act = observe();
        checks++;
        if (act !== {EN_F, 1'b0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", act, {EN_F, 1'b0, 2'd3, 1'b0});
        end
    endtask

    task automatic test_alu_latency();
        do_reset();
        add_instr(16'h1261, 3'b000, 3'b000, 0, 0, 0);
        push(EN_F, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        run_queue("alu_latency", 1000);
    endtask

    task automatic test_ldi();
        do_reset();
        add_instr(16'hA200, 3'b000, 3'b000, 0, 2, 2);
        add_instr(16'hB000, 3'b000, 3'b000, 1, 3, 0);
        run_queue("ldi_sti", 1000);
    endtask

    task automatic test_branch();
        do_reset();
        add_instr(16'h0400, 3'b010, 3'b010, 0, 0, 0);
        add_instr(16'h0400, 3'b010, 3'b100, 0, 0, 0);
        add_instr(16'h0000, 3'b000, 3'b111, 1, 0, 0);
        add_instr(16'hC1C0, 3'b000, 3'b000, 0, 0, 0);
        add_instr(16'h0E00, 3'b111, 3'b001, 2, 0, 0);
        run_queue("branch", 1000);
    endtask

    task automatic test_timeout();
        do_reset();
        add_instr(16'h3000, 3'b000, 3'b000, 0, 1000, 0);
        add_instr(16'h3000, 3'b000, 3'b000, 0, TO - 1, 0);
        add_instr(16'h7000, 3'b000, 3'b000, 0, TO, 0);
        add_instr(16'h2000, 3'b000, 3'b000, 0, TO - 1, 0);
        add_instr(16'hA000, 3'b000, 3'b000, 0, 0, TO);
        add_instr(16'h1261, 3'b000, 3'b000, TO - 1, 0, 0);
        add_instr(16'h1261, 3'b000, 3'b000, TO, 0, 0);
        run_queue("timeout", 5000);
    endtask

    task automatic test_reset_mid_mem();
        logic [9:0] act;
        do_reset();
        add_instr(16'h2000, 3'b000, 3'b000, 0, 500, 0);
        run_queue("reset_mid_mem_pre", 7);
        reset = 1'b1;
        @(negedge clock);
        act = observe();
        checks++;
        if (act !== 10'b00000_0_11_0) begin
            errors++;
            $display("FAIL reset_mid_mem: got %b expected %b", act, 10'b00000_0_11_0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        cur_ir = 16'h2000;
        void'(wait_phase(EN_F, 2'd3, TO, 1'b1));
        run_queue("reset_mid_mem_post", 1000);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int d[3];
            for (int j = 0; j < 3; j++)
                d[j] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(TO - 3, TO + 3))
                                                    : int'($urandom_range(0, 3));
            add_instr(16'($urandom), 3'($urandom), 3'($urandom), d[0], d[1], d[2]);
        end
        run_queue("random", 20000);
    endtask

`ifdef FETCH_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) add_instr(16'h1261, 3'b000, 3'b000, 0, 0, 0);
        run_queue("perf_three", 1000);
        checks++;
        if (retired_cnt !== 16'd3) begin
            errors++;
            $display("FAIL perf_three: got %h expected %h", retired_cnt, 16'd3);
        end
        do_reset();
        dut.retired_cnt_q = 16'hFFFF;
        add_instr(16'h1261, 3'b000, 3'b000, 0, 0, 0);
        run_queue("perf_wrap_run", 1000);
        checks++;
        if (retired_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL perf_wrap: got %h expected %h", retired_cnt, 16'h0000);
        end
    endtask
`endif

    initial begin
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        bus.IR             = 16'h0000;
        bus.NZP            = 3'b000;
        bus.psr            = 3'b000;
        cur_ir             = 16'h0000;
        cur_nzp            = 3'b000;
        cur_psr            = 3'b000;
        test_reset();
        test_alu_latency();
        test_ldi();
        test_branch();
        test_timeout();
        test_reset_mid_mem();
        test_random();
`ifdef FETCH_CTRL_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
